// File: rtl/irq_queue_if.sv
// irq_queue_if -- event/handshake bundle between interrupt sources, the
// irq_queue block and the CPU.
//   src_req  [3:0]  one-cycle event pulses, bit 0 = UART rx byte valid
//   rx_byte  [7:0]  UART rx byte, meaningful when src_req[0]=1
//   mask     [3:0]  1 = source enabled
//   ack             CPU acknowledge (level, rising edge pops the head)
//   clr_ovf         one-cycle pulse clearing all overflow flags
//   irr             interrupt request to the CPU
//   ev_data  [7:0]  head event payload
//   ev_src   [1:0]  head event source index
//   ovf      [3:0]  sticky per-source overflow flags
//   count           number of queued events
// master = sources/CPU side, slave = irq_queue.
interface irq_queue_if #(
    parameter int DEPTH = 4
);
    logic [3:0]               src_req;
    logic [7:0]               rx_byte;
    logic [3:0]               mask;
    logic                     ack;
    logic                     clr_ovf;
    logic                     irr;
    logic [7:0]               ev_data;
    logic [1:0]               ev_src;
    logic [3:0]               ovf;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output src_req, rx_byte, mask, ack, clr_ovf,
        input  irr, ev_data, ev_src, ovf, count
    );

    modport slave (
        input  src_req, rx_byte, mask, ack, clr_ovf,
        output irr, ev_data, ev_src, ovf, count
    );
endinterface

// File: rtl/irq_queue.sv
// irq_queue -- collects one-cycle event pulses from four sources into
// per-source pending bits, moves them one per cycle (lowest index first)
// into a DEPTH-entry event FIFO, and presents the FIFO head to the CPU
// through an irr/ack handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    irq_queue_if.slave (src_req, rx_byte, mask, ack, clr_ovf in;
//          irr, ev_data, ev_src, ovf, count out)
module irq_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    irq_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      pending_q, pending_d;
    logic [7:0]      payload_q, payload_d;
    logic [3:0]      ovf_q, ovf_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ack_prev_q, ack_prev_d;

    logic [3:0]      req_en;
    logic            push;
    logic            pop;
    logic [1:0]      push_src;
    logic [3:0]      push_onehot;
    logic [7:0]      push_data;
    logic            ack_edge;

    logic [7:0]      mem_data [DEPTH];
    logic [1:0]      mem_src  [DEPTH];

    assign req_en   = bus.src_req & bus.mask;
    assign ack_edge = bus.ack & ~ack_prev_q;

    // Lowest-index pending source wins; nothing moves while the FIFO is full.
    always_comb begin
        push_src = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_src = 2'(i);
            end
        end
        push        = (pending_q != 4'd0) && (count_q < CW'(DEPTH));
        push_onehot = push ? (4'b0001 << push_src) : 4'b0000;
        push_data   = (push_src == 2'd0) ? payload_q : 8'h00;
    end

    // A request landing in the same cycle its pending bit is pushed simply
    // re-arms the bit; only a request hitting a bit that stays pending is an
    // overflow. A same-cycle overflow set beats clr_ovf.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = bus.clr_ovf ? 4'd0 : ovf_q;
        payload_d = payload_q;
        for (int i = 0; i < 4; i++) begin
            pending_d[i] = req_en[i] | (pending_q[i] & ~push_onehot[i]);
            if (req_en[i] && pending_q[i] && !push_onehot[i]) begin
                ovf_d[i] = 1'b1;
            end
        end
        // The newest byte always wins; an older one still pending is lost
        // (and flagged through ovf[0] above).
        if (req_en[0]) begin
            payload_d = bus.rx_byte;
        end
    end

    // Handshake FSM. Pops happen only on a fresh ack rise while in REQ, so a
    // CPU holding ack high cannot drain more than one event.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_edge && (count_q != '0)) begin
                    pop     = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        ack_prev_d = bus.ack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            payload_q  <= '0;
            ovf_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            payload_q  <= payload_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_src[wr_ptr_q]  <= push_src;
        end
    end

    assign bus.irr     = (state_q == REQ);
    assign bus.ev_data = (count_q != '0) ? mem_data[rd_ptr_q] : 8'h00;
    assign bus.ev_src  = (count_q != '0) ? mem_src[rd_ptr_q]  : 2'd0;
    assign bus.ovf     = ovf_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_irq_queue.sv
// tb_irq_queue -- self-checking bench for irq_queue. Inputs change and
// outputs are sampled on the falling clock edge. Expected events are queued
// when stimulus is driven and compared when the DUT raises irr.
module tb_irq_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    irq_queue_if #(.DEPTH(DEPTH)) bus ();

    irq_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] r, input logic [7:0] b);
        bus.src_req = r;
        bus.rx_byte = b;
        step();
        bus.src_req = 4'd0;
    endtask

    task automatic wait_irr(input string tag, output bit ok);
        int n = 0;
        while (!bus.irr && n < 50) begin
            step();
            n++;
        end
        ok = bus.irr;
        if (!ok) begin
            check({tag, " irr timeout"}, 32'd0, 32'd1);
        end
    endtask

    // Wait for irr, compare the head against the scoreboard, then ack with
    // ack held high for 'hold' cycles before releasing it.
    task automatic consume(input string tag, input int hold);
        bit  ok;
        ev_t e;
        int  irr_seen = 0;
        wait_irr(tag, ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            check({tag, " unexpected event"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        $display("event %s: src=%0d data=%02h (exp src=%0d data=%02h)",
                 tag, bus.ev_src, bus.ev_data, e.src, e.data);
        check({tag, " ev_src"},  32'(bus.ev_src),  32'(e.src));
        check({tag, " ev_data"}, 32'(bus.ev_data), 32'(e.data));
        bus.ack = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (bus.irr) irr_seen++;
        end
        check({tag, " irr while ack high"}, 32'(irr_seen), 32'd0);
        bus.ack = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.src_req = 4'd0;
        bus.rx_byte = 8'd0;
        bus.mask    = 4'hF;
        bus.ack     = 1'b0;
        bus.clr_ovf = 1'b0;
        reset       = 1'b1;
        repeat (3) step();
        check("reset irr",     32'(bus.irr),     32'd0);
        check("reset count",   32'(bus.count),   32'd0);
        check("reset ovf",     32'(bus.ovf),     32'd0);
        check("reset ev_data", 32'(bus.ev_data), 32'd0);
        check("reset ev_src",  32'(bus.ev_src),  32'd0);
        reset = 1'b0;
        step();

        // Single UART event with exact latencies.
        pulse(4'b0001, 8'h41);
        step();
        check("single count", 32'(bus.count), 32'd1);
        check("single irr early", 32'(bus.irr), 32'd0);
        step();
        check("single irr",     32'(bus.irr),     32'd1);
        check("single ev_data", 32'(bus.ev_data), 32'h41);
        check("single ev_src",  32'(bus.ev_src),  32'd0);
        $display("event single: src=%0d data=%02h", bus.ev_src, bus.ev_data);
        bus.ack = 1'b1;
        step();
        check("single irr after ack",   32'(bus.irr),   32'd0);
        check("single count after ack", 32'(bus.count), 32'd0);
        bus.ack = 1'b0;
        step();

        // Priority: sources 1 and 3 together, one push per cycle.
        pulse(4'b1010, 8'h00);
        step();
        check("prio count1", 32'(bus.count), 32'd1);
        step();
        check("prio count2", 32'(bus.count), 32'd2);
        exp_q.push_back('{src: 2'd1, data: 8'h00});
        exp_q.push_back('{src: 2'd3, data: 8'h00});
        consume("prio a", 1);
        consume("prio b", 1);
        check("prio drained", 32'(bus.count), 32'd0);

        // Full FIFO, held pending, overflow.
        pulse(4'b1111, 8'h55);
        repeat (5) step();
        check("full count", 32'(bus.count), 32'd4);
        exp_q.push_back('{src: 2'd0, data: 8'h55});
        exp_q.push_back('{src: 2'd1, data: 8'h00});
        exp_q.push_back('{src: 2'd2, data: 8'h00});
        exp_q.push_back('{src: 2'd3, data: 8'h00});
        pulse(4'b0100, 8'h00);
        repeat (2) step();
        check("full count held", 32'(bus.count), 32'd4);
        check("full no ovf yet", 32'(bus.ovf),   32'd0);
        pulse(4'b0100, 8'h00);
        check("full ovf2", 32'(bus.ovf), 32'h4);
        exp_q.push_back('{src: 2'd2, data: 8'h00});
        consume("full 0", 1);
        check("full refilled", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) consume("full drain", 1);
        repeat (3) step();
        check("full drained", 32'(bus.count), 32'd0);

        // Held ack: exactly one pop, no irr until ack falls.
        pulse(4'b0011, 8'h77);
        exp_q.push_back('{src: 2'd0, data: 8'h77});
        exp_q.push_back('{src: 2'd1, data: 8'h00});
        consume("held", 10);
        check("held one pop", 32'(bus.count), 32'd1);
        consume("held second", 1);

        // Masked source produces nothing.
        bus.mask = 4'b1110;
        pulse(4'b0001, 8'h33);
        repeat (4) step();
        check("mask count", 32'(bus.count), 32'd0);
        check("mask irr",   32'(bus.irr),   32'd0);
        bus.mask = 4'hF;

        // clr_ovf in the same cycle as a source-2 overflow: set wins.
        bus.src_req = 4'b0101;
        bus.rx_byte = 8'h9A;
        step();
        bus.src_req = 4'b0100;
        bus.clr_ovf = 1'b1;
        step();
        bus.src_req = 4'd0;
        bus.clr_ovf = 1'b0;
        check("clr vs set ovf", 32'(bus.ovf), 32'h4);
        exp_q.push_back('{src: 2'd0, data: 8'h9A});
        exp_q.push_back('{src: 2'd2, data: 8'h00});
        consume("ovf a", 1);
        consume("ovf b", 1);
        repeat (3) step();
        check("ovf drained", 32'(bus.count), 32'd0);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        check("clr ovf", 32'(bus.ovf), 32'd0);

        // Request in the same cycle its pending bit is pushed: re-arm, no ovf.
        bus.src_req = 4'b0100;
        step();
        step();
        bus.src_req = 4'd0;
        check("rearm count1", 32'(bus.count), 32'd1);
        step();
        check("rearm count2", 32'(bus.count), 32'd2);
        check("rearm no ovf", 32'(bus.ovf),   32'd0);
        exp_q.push_back('{src: 2'd2, data: 8'h00});
        exp_q.push_back('{src: 2'd2, data: 8'h00});
        consume("rearm a", 1);
        consume("rearm b", 1);

        // Reset in the middle of a handshake, ack still high afterwards.
        pulse(4'b1000, 8'h00);
        wait_irr("rst", ok);
        check("rst head src", 32'(bus.ev_src), 32'd3);
        bus.ack = 1'b1;
        reset   = 1'b1;
        step();
        check("rst irr",    32'(bus.irr),    32'd0);
        check("rst count",  32'(bus.count),  32'd0);
        check("rst ev_src", 32'(bus.ev_src), 32'd0);
        reset = 1'b0;
        step();
        pulse(4'b0010, 8'h00);
        repeat (6) step();
        check("rst no pop", 32'(bus.count), 32'd1);
        check("rst irr up", 32'(bus.irr),   32'd1);
        bus.ack = 1'b0;
        step();
        exp_q.push_back('{src: 2'd1, data: 8'h00});
        consume("rst after", 1);

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
